// File: rtl/keypad_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator_if
//  Description : Scanner-side bundle of the keypad emulator: column strobe
//                in, row lines out, plus the key request/status handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_emulator_if;
    logic [3:0] col;
    logic [3:0] fila;
    logic [4:0] key_code;
    logic       key_valid;
    logic       busy;
    logic       done;
    logic       err;

    // Requester / scanner side
    modport master (
        output col, key_code, key_valid,
        input  fila, busy, done, err
    );

    // Emulator side
    modport slave (
        input  col, key_code, key_valid,
        output fila, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator
//  Description : Emulates a 4x4 matrix keypad. A requested key is held
//                closed for HOLD_TICKS cycles, then released for GAP_TICKS
//                cycles. Row lines respond combinationally to the column
//                strobe so the scanner decodes in the same cycle.
//                Optional macro KEYPAD_BOUNCE_EN adds contact-bounce gating
//                over the first BOUNCE_TICKS cycles of each press.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_TICKS   = 20,
    parameter int GAP_TICKS    = 10,
    parameter int BOUNCE_TICKS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    keypad_emulator_if.slave  bus
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);

    // Parameter sanity checks at elaboration
    if (HOLD_TICKS < 1 || HOLD_TICKS > 65535) begin : g_bad_hold
        $error("keypad_emulator: HOLD_TICKS out of range");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 65535) begin : g_bad_gap
        $error("keypad_emulator: GAP_TICKS out of range");
    end
    if (BOUNCE_TICKS < 1 || BOUNCE_TICKS > HOLD_TICKS) begin : g_bad_bounce
        $error("keypad_emulator: BOUNCE_TICKS out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] counter, counter_n;
    logic [3:0]  target_row, target_row_n;
    logic [3:0]  target_col, target_col_n;
    logic        busy_q, done_q, err_q;
    logic        done_n, err_n;
    logic [3:0]  fila_w;

    // Key code to {row, col} one-hot position on the 4x4 matrix
    function automatic logic [7:0] key_position(input logic [3:0] code);
        logic [7:0] pos;
        case (code)
            4'h1:    pos = {4'b0001, 4'b0001};
            4'h2:    pos = {4'b0001, 4'b0010};
            4'h3:    pos = {4'b0001, 4'b0100};
            4'hA:    pos = {4'b0001, 4'b1000};
            4'h4:    pos = {4'b0010, 4'b0001};
            4'h5:    pos = {4'b0010, 4'b0010};
            4'h6:    pos = {4'b0010, 4'b0100};
            4'hB:    pos = {4'b0010, 4'b1000};
            4'h7:    pos = {4'b0100, 4'b0001};
            4'h8:    pos = {4'b0100, 4'b0010};
            4'h9:    pos = {4'b0100, 4'b0100};
            4'hC:    pos = {4'b0100, 4'b1000};
            4'hF:    pos = {4'b1000, 4'b0001};
            4'h0:    pos = {4'b1000, 4'b0010};
            4'hE:    pos = {4'b1000, 4'b0100};
            default: pos = {4'b1000, 4'b1000};   // 4'hD
        endcase
        return pos;
    endfunction

    // State, counter, target and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= 16'd0;
            target_row <= 4'd0;
            target_col <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            counter    <= counter_n;
            target_row <= target_row_n;
            target_col <= target_col_n;
            busy_q     <= (state_n != IDLE);
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    // Next-state logic: accept in IDLE, reject any request while busy
    always_comb begin
        state_n      = state;
        counter_n    = counter;
        target_row_n = target_row;
        target_col_n = target_col;
        done_n       = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    if (bus.key_code[4]) begin
                        err_n = 1'b1;
                    end else begin
                        state_n                     = PRESS;
                        counter_n                   = 16'd0;
                        {target_row_n, target_col_n} = key_position(bus.key_code[3:0]);
                    end
                end
            end
            PRESS: begin
                err_n = bus.key_valid;
                if (counter == HOLD_LAST) begin
                    state_n   = GAP;
                    counter_n = 16'd0;
                end else begin
                    counter_n = counter + 16'd1;
                end
            end
            GAP: begin
                err_n = bus.key_valid;
                if (counter == GAP_LAST) begin
                    state_n   = IDLE;
                    counter_n = 16'd0;
                    done_n    = 1'b1;
                end else begin
                    counter_n = counter + 16'd1;
                end
            end
            default: begin
                state_n   = IDLE;
                counter_n = 16'd0;
            end
        endcase
    end

    // Row response: the target column is one-hot, so equality also rejects
    // any non-one-hot strobe
    always_comb begin
        fila_w = 4'b0000;
        if (state == PRESS && bus.col == target_col) begin
            fila_w = target_row;
        end
`ifdef KEYPAD_BOUNCE_EN
        if (counter < 16'(BOUNCE_TICKS) && counter[0]) begin
            fila_w = 4'b0000;
        end
`endif
    end

    assign bus.fila = fila_w;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire
